// File: rtl/carry_la_slice_if.sv
// Operand/result bundle for carry_la_slice; master drives operands, slave is the adder slice.
// Carries the ovf signal only when CARRY_LA_SLICE_OVF_EN is defined.
interface carry_la_slice_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic             grp_g;
    logic             grp_p;
    logic             cout;
`ifdef CARRY_LA_SLICE_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin,
        input  out_valid, sum, gen, prop, grp_g, grp_p, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin,
        output out_valid, sum, gen, prop, grp_g, grp_p, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin,
        input  out_valid, sum, gen, prop, grp_g, grp_p, cout
    );
    modport slave (
        input  in_valid, a, b, cin,
        output out_valid, sum, gen, prop, grp_g, grp_p, cout
    );
`endif
endinterface

// File: rtl/carry_la_slice.sv
// Registered carry-lookahead adder slice with group generate/propagate for cascading.
// Optional signed-overflow output enabled by defining CARRY_LA_SLICE_OVF_EN.
module carry_la_slice #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    carry_la_slice_if.slave bus
);
    logic [WIDTH-1:0] gen_d;
    logic [WIDTH-1:0] prop_d;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] gen_term;
    logic [WIDTH-1:0] prop_run;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] gen_q;
    logic [WIDTH-1:0] prop_q;
    logic             grp_g_q;
    logic             grp_p_q;
    logic             cout_q;

    assign gen_d    = bus.a & bus.b;
    assign prop_d   = bus.a ^ bus.b;
    assign carry[0] = bus.cin;

    // Each carry is an independent sum of products over bits 0..gi, so no
    // carry depends on a lower-order carry signal.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lookahead
            always_comb begin
                logic term_or;
                logic prod;
                term_or = 1'b0;
                for (int j = 0; j <= gi; j++) begin
                    prod = gen_d[j];
                    for (int k = j + 1; k <= gi; k++) begin
                        prod = prod & prop_d[k];
                    end
                    term_or = term_or | prod;
                end
                gen_term[gi] = term_or;
            end

            assign prop_run[gi]  = &prop_d[gi:0];
            assign carry[gi + 1] = gen_term[gi] | (prop_run[gi] & bus.cin);
            assign sum_d[gi]     = prop_d[gi] ^ carry[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            gen_q       <= '0;
            prop_q      <= '0;
            grp_g_q     <= 1'b0;
            grp_p_q     <= 1'b0;
            cout_q      <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q   <= sum_d;
                gen_q   <= gen_d;
                prop_q  <= prop_d;
                grp_g_q <= gen_term[WIDTH-1];
                grp_p_q <= prop_run[WIDTH-1];
                cout_q  <= carry[WIDTH];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.gen       = gen_q;
    assign bus.prop      = prop_q;
    assign bus.grp_g     = grp_g_q;
    assign bus.grp_p     = grp_p_q;
    assign bus.cout      = cout_q;

`ifdef CARRY_LA_SLICE_OVF_EN
    logic ovf_q;

    // Two's-complement overflow: carry into the sign bit differs from carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (bus.in_valid) begin
            ovf_q <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_carry_la_slice.sv
// Self-checking bench for carry_la_slice: directed cases, exhaustive sweep and random traffic
// against an arithmetic reference model.
module tb_carry_la_slice;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;

    carry_la_slice_if #(.WIDTH(WIDTH)) bus ();

    carry_la_slice #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: what the registered outputs should currently show.
    logic             exp_valid;
    logic [WIDTH-1:0] exp_sum, exp_gen, exp_prop;
    logic             exp_grp_g, exp_grp_p, exp_cout, exp_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        exp_valid = 1'b0; exp_sum = '0; exp_gen = '0; exp_prop = '0;
        exp_grp_g = 1'b0; exp_grp_p = 1'b0; exp_cout = 1'b0; exp_ovf = 1'b0;
    endtask

    task automatic model_load(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic c);
        int tot, sa, sb, st;
        tot       = int'(av) + int'(bv) + int'(c);
        exp_sum   = WIDTH'(tot % (1 << WIDTH));
        exp_cout  = (tot >= (1 << WIDTH));
        exp_gen   = av & bv;
        exp_prop  = av ^ bv;
        // Group generate: the slice produces a carry even with no carry in.
        exp_grp_g = ((int'(av) + int'(bv)) >= (1 << WIDTH));
        exp_grp_p = (exp_prop == {WIDTH{1'b1}});
        sa = av[WIDTH-1] ? int'(av) - (1 << WIDTH) : int'(av);
        sb = bv[WIDTH-1] ? int'(bv) - (1 << WIDTH) : int'(bv);
        st = sa + sb + int'(c);
        exp_ovf = (st > (1 << (WIDTH-1)) - 1) || (st < -(1 << (WIDTH-1)));
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_valid));
        check({tag, ".sum"},       32'(bus.sum),       32'(exp_sum));
        check({tag, ".cout"},      32'(bus.cout),      32'(exp_cout));
        check({tag, ".gen"},       32'(bus.gen),       32'(exp_gen));
        check({tag, ".prop"},      32'(bus.prop),      32'(exp_prop));
        check({tag, ".grp_g"},     32'(bus.grp_g),     32'(exp_grp_g));
        check({tag, ".grp_p"},     32'(bus.grp_p),     32'(exp_grp_p));
`ifdef CARRY_LA_SLICE_OVF_EN
        check({tag, ".ovf"},       32'(bus.ovf),       32'(exp_ovf));
`endif
    endtask

    task automatic drive(input string tag, input logic v, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input logic c);
        @(negedge clk);
        bus.in_valid = v; bus.a = av; bus.b = bv; bus.cin = c;
        @(posedge clk);
        #1;
        exp_valid = v;
        if (v) model_load(av, bv, c);
        check_all(tag);
        $display("%s v=%0d a=%h b=%h cin=%0d -> ov=%0d sum=%h cout=%0d", tag, v, av, bv, c,
                 bus.out_valid, bus.sum, bus.cout);
    endtask

    initial begin
        model_clear();
        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.a = 4'hF; bus.b = 4'hF; bus.cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        $display("reset held with in_valid=1 a=f b=f -> sum=%h cout=%0d", bus.sum, bus.cout);

        @(negedge clk);
        rst_n = 1'b1;
        drive("post_reset", 1'b1, 4'hF, 4'hF, 1'b0);
        check("post_reset.sum_e", 32'(bus.sum), 32'hE);

        drive("basic", 1'b1, 4'h3, 4'h5, 1'b0);
        drive("full_prop", 1'b1, 4'hF, 4'h0, 1'b1);
        drive("zero", 1'b1, 4'h0, 4'h0, 1'b0);
        drive("b2b_1", 1'b1, 4'h7, 4'h1, 1'b0);
        drive("b2b_2", 1'b1, 4'h9, 4'h9, 1'b1);
        drive("idle", 1'b0, 4'h5, 4'h5, 1'b0);
        check("idle.hold_sum", 32'(bus.sum), 32'h3);

        drive("ovf_1", 1'b1, 4'h7, 4'h1, 1'b0);
        drive("ovf_2", 1'b1, 4'h8, 4'h8, 1'b0);
        drive("ovf_3", 1'b1, 4'h2, 4'h3, 1'b0);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            drive("sweep", 1'b1, v[3:0], v[7:4], v[8]);
        end

        for (int i = 0; i < 200; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            drive("rand", ($urandom_range(0, 3) != 0), ra, rb, 1'($urandom));

            if (i == 100) begin
                @(negedge clk);
                bus.in_valid = 1'b1; bus.a = 4'hC; bus.b = 4'h7; bus.cin = 1'b1;
                #2;
                rst_n = 1'b0;
                #1;
                model_clear();
                check_all("async_rst");
                $display("async reset mid-stream -> ov=%0d sum=%h", bus.out_valid, bus.sum);
                @(posedge clk);
                #1;
                check_all("rst_hold");
                @(negedge clk);
                bus.in_valid = 1'b0;
                rst_n = 1'b1;
                drive("after_rst_idle", 1'b0, 4'h1, 4'h1, 1'b0);
                drive("after_rst_first", 1'b1, 4'hA, 4'h6, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/carry_la_slice.md
Name: carry_la_slice

Overview:
- Registered, parameterized carry-lookahead adder slice built from per-bit generate/propagate cells.
- Per bit: g = a & b, p = a ^ b, s = p ^ c.
- Carries come from lookahead equations, not a ripple chain.
- Block-level group generate/propagate outputs let slices be cascaded by a higher-level lookahead unit (e.g. 4-bit slices in the datapath ALU).

Parameters:
- WIDTH, 4, operand width in bits (legal range 1..32).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and carry-in valid this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- out_valid  output  1  registered outputs valid
- sum  output  WIDTH  registered sum
- gen  output  WIDTH  registered per-bit generate, a[i] & b[i]
- prop  output  WIDTH  registered per-bit propagate, a[i] ^ b[i]
- grp_g  output  1  registered group generate
- grp_p  output  1  registered group propagate, AND of all prop bits
- cout  output  1  registered carry out of bit WIDTH-1

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- While rst_n = 0: out_valid, sum, gen, prop, grp_g, grp_p and cout are all 0.
- Combinational core:
  - c[0] = cin.
  - c[i+1] = g[i] | (p[i] & c[i]), implemented as flattened lookahead sums of products, no chained gate path.
  - s[i] = p[i] ^ c[i].
  - grp_g = g[W-1] | p[W-1]g[W-2] | ... | p[W-1..1]g[0].
  - grp_p = &p.
  - cout = grp_g | (grp_p & cin).
- Latency is exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- out_valid is a registered copy of in_valid.
- Data registers load only when in_valid = 1. When in_valid = 0 they hold their previous values and out_valid drops to 0.
- No backpressure. A new operand set may be accepted every cycle.
- Arithmetic is unsigned modulo 2^WIDTH. {cout, sum} = a + b + cin exactly.
- Boundary cases:
  - All-ones a with b = 0 and cin = 1: full propagate chain. sum = 0, cout = 1, grp_p = 1, grp_g = 0.
  - a = b = 0, cin = 0: all outputs 0.
  - Reset asserted mid-stream: outputs clear immediately and asynchronously. The first valid output after deassertion comes from the first in_valid sampled after deassertion.
  - WIDTH = 1: grp_g = g[0], grp_p = p[0].

Optional Feature:
- Macro: CARRY_LA_SLICE_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), registered on the same enable as sum.
  - ovf = c[WIDTH] ^ c[WIDTH-1], the two's-complement signed overflow.
  - ovf resets to 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n = 0 with in_valid = 1, a = 4'hF, b = 4'hF -> all outputs 0. Release rst_n, then one edge -> sum = 4'hE, cout = 1, out_valid = 1.
- WIDTH = 4, a = 4'h3, b = 4'h5, cin = 0 -> next cycle: sum = 4'h8, cout = 0, gen = 4'h1, prop = 4'h6, grp_g = 0, grp_p = 0.
- Full propagate: a = 4'hF, b = 4'h0, cin = 1 -> sum = 4'h0, cout = 1, prop = 4'hF, grp_p = 1, grp_g = 0.
- Back-to-back: cycle 1 a = 4'h7, b = 4'h1, cin = 0; cycle 2 a = 4'h9, b = 4'h9, cin = 1 -> outputs 4'h8/cout 0, then 4'h3/cout 1, out_valid high both cycles. Then in_valid = 0 -> out_valid = 0 and sum holds 4'h3.
- Exhaustive WIDTH = 4 sweep of all a, b and cin -> {cout, sum} == a + b + cin and gen/prop match their bitwise definitions on every vector.
- With CARRY_LA_SLICE_OVF_EN: a = 4'h7, b = 4'h1, cin = 0 -> ovf = 1. Then a = 4'h8, b = 4'h8, cin = 0 -> ovf = 1, cout = 1, sum = 0. Then a = 4'h2, b = 4'h3 -> ovf = 0.
